// File: rtl/dpp_table_pkg.sv
// Shared definitions for the dining-philosophers fork table.
//   - Event codes a philo places in its FIFO (PHILO_HUNGRY / PHILO_DONE).
//   - Boolean shorthands TRUE / FALSE.
//   - Table FSM state codes TBL_SCAN .. TBL_SETTLE.
//   - log2(): index width for a given philo count.
package dpp_table_pkg;

  localparam logic PHILO_HUNGRY = 1'b1;
  localparam logic PHILO_DONE   = 1'b0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [2:0] {
    TBL_SCAN   = 3'd0,
    TBL_EVAL   = 3'd1,
    TBL_CHK_L  = 3'd2,
    TBL_CHK_R  = 3'd3,
    TBL_SETTLE = 3'd4
  } tbl_state_e;

  // Bits needed to index n items; never less than 1 so a 1-bit index exists for n=2.
  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dpp_rr_pick.sv
// Rotating-priority finder.
// Returns the first asserted request at or after ptr, wrapping past N-1 to 0.
//   req    in   N  request vector
//   ptr    in   W  position with highest priority (must be < N)
//   found  out  1  at least one request is asserted
//   idx    out  W  index of the winning request (0 when none found)
module dpp_rr_pick
  import dpp_table_pkg::*;
#(
  parameter  int N = 5,
  localparam int W = log2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;

  // NOTE: every variable driven here gets a value before any branch, so no latch can be inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = (cand == W'(N - 1)) ? '0 : cand + W'(1);
    end
  end

endmodule

// File: rtl/dpp_table.sv
// Central fork arbiter ("table") for the dining-philosophers design.
// Drains the philo event FIFOs round-robin, owns all fork state and issues
// single-cycle may_eat grants. Philo i uses fork i (left) and fork i+1 (right).
//   clk         in   1  clock
//   reset       in   1  asynchronous, active-high
//   fout_empty  in   N  per-philo FIFO empty (first-word fall-through)
//   fout_data   in   N  per-philo FIFO head: PHILO_HUNGRY or PHILO_DONE
//   fout_ack    out  N  FIFO pop, one-hot single-cycle pulse
//   hungry      in   N  philo hungry lines, only used by the run-time checks
//   may_eat     out  N  grant, single-cycle pulse
//   fork_busy   out  N  fork i is held
//   eating      out  N  philo i granted and not yet DONE
//   waiting     out  N  philo i HUNGRY but not yet granted
//   proto_err   out  1  sticky protocol error, cleared only by reset
module dpp_table
  import dpp_table_pkg::*;
#(
  parameter  int N_PHILO = 5,
  localparam int IDX_W   = log2(N_PHILO)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PHILO-1:0] fout_empty,
  input  logic [N_PHILO-1:0] fout_data,
  output logic [N_PHILO-1:0] fout_ack,
  input  logic [N_PHILO-1:0] hungry,
  output logic [N_PHILO-1:0] may_eat,
  output logic [N_PHILO-1:0] fork_busy,
  output logic [N_PHILO-1:0] eating,
  output logic [N_PHILO-1:0] waiting,
  output logic               proto_err
);

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_PHILO - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] prv(input logic [IDX_W-1:0] i);
    return (i == '0) ? IDX_W'(N_PHILO - 1) : i - IDX_W'(1);
  endfunction

  tbl_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ev_q, ev_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_PHILO-1:0] ack_d, me_d, busy_d, eat_d, wait_d;
  logic               err_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   l_idx, r_idx, rr_idx;

  dpp_rr_pick #(.N(N_PHILO)) u_pick (
    .req   (~fout_empty),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Neighbours of the philo being serviced. Philo L needs forks L and idx;
  // philo R needs forks R and R+1.
  assign l_idx  = prv(idx_q);
  assign r_idx  = nxt(idx_q);
  assign rr_idx = nxt(r_idx);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ev_d    = ev_q;
    ptr_d   = ptr_q;
    busy_d  = fork_busy;
    eat_d   = eating;
    wait_d  = waiting;
    err_d   = proto_err;
    ack_d   = '0;
    me_d    = '0;

    unique case (state_q)
      TBL_SCAN: begin
        if (pick_found) begin
          idx_d           = pick_idx;
          ev_d            = fout_data[pick_idx];
          ack_d[pick_idx] = TRUE;
          state_d         = TBL_EVAL;
        end
      end

      TBL_EVAL: begin
        if (ev_q == PHILO_HUNGRY) begin
          state_d = TBL_SETTLE;
          if (eating[idx_q] || waiting[idx_q]) begin
            err_d = TRUE;
          end else if (!fork_busy[idx_q] && !fork_busy[r_idx]) begin
            busy_d[idx_q] = TRUE;
            busy_d[r_idx] = TRUE;
            eat_d[idx_q]  = TRUE;
            me_d[idx_q]   = TRUE;
          end else begin
            wait_d[idx_q] = TRUE;
          end
        end else if (!eating[idx_q]) begin
          err_d   = TRUE;
          state_d = TBL_SETTLE;
        end else begin
          busy_d[idx_q] = FALSE;
          busy_d[r_idx] = FALSE;
          eat_d[idx_q]  = FALSE;
          state_d       = TBL_CHK_L;
        end
      end

      // The freed forks may complete a waiting neighbour's pair.
      TBL_CHK_L: begin
        if (waiting[l_idx] && !fork_busy[l_idx] && !fork_busy[idx_q]) begin
          busy_d[l_idx] = TRUE;
          busy_d[idx_q] = TRUE;
          eat_d[l_idx]  = TRUE;
          wait_d[l_idx] = FALSE;
          me_d[l_idx]   = TRUE;
        end
        state_d = TBL_CHK_R;
      end

      // Sees fork state already updated by CHK_L, so with two philos (L == R)
      // the same neighbour cannot be granted twice.
      TBL_CHK_R: begin
        if (waiting[r_idx] && !fork_busy[r_idx] && !fork_busy[rr_idx]) begin
          busy_d[r_idx]  = TRUE;
          busy_d[rr_idx] = TRUE;
          eat_d[r_idx]   = TRUE;
          wait_d[r_idx]  = FALSE;
          me_d[r_idx]    = TRUE;
        end
        state_d = TBL_SETTLE;
      end

      // One idle cycle so the popped FIFO's empty flag is valid before the next scan.
      TBL_SETTLE: begin
        ptr_d   = r_idx;
        state_d = TBL_SCAN;
      end

      default: state_d = TBL_SCAN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= TBL_SCAN;
      idx_q     <= '0;
      ev_q      <= 1'b0;
      ptr_q     <= '0;
      fout_ack  <= '0;
      may_eat   <= '0;
      fork_busy <= '0;
      eating    <= '0;
      waiting   <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ev_q      <= ev_d;
      ptr_q     <= ptr_d;
      fout_ack  <= ack_d;
      may_eat   <= me_d;
      fork_busy <= busy_d;
      eating    <= eat_d;
      waiting   <= wait_d;
      proto_err <= err_d;
    end
  end

  // Run-time checks: a granted philo must drop hungry within two cycles, and
  // the pulse / ownership invariants must hold every cycle.
  logic [N_PHILO-1:0] hungry_eating;
  assign hungry_eating = hungry & eating;

  for (genvar g = 0; g < N_PHILO; g++) begin : g_chk
    hungry_while_eating: assert property (@(posedge clk) disable iff (reset)
      !(hungry_eating[g] && $past(hungry_eating[g]) && $past(hungry_eating[g], 2)));
  end

  table_invariants: assert property (@(posedge clk) disable iff (reset)
    $onehot0(may_eat) && $onehot0(fout_ack) && ((eating & waiting) == '0));

endmodule

// File: tb/tb_dpp_table.sv
// Self-checking bench for dpp_table (N_PHILO = 5).
// Philo FIFOs are modelled with queues; a transaction-level reference model
// decides, per serviced event, the expected ack/grant cycles and the fork,
// eating, waiting and error state once the table is back in SCAN.
module tb_dpp_table;
  import dpp_table_pkg::*;

  localparam int N = 5;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] fout_empty, fout_data, fout_ack, hungry, may_eat;
  logic [N-1:0] fork_busy, eating, waiting;
  logic         proto_err;

  always #5 clk = ~clk;

  dpp_table #(.N_PHILO(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .fout_empty (fout_empty),
    .fout_data  (fout_data),
    .fout_ack   (fout_ack),
    .hungry     (hungry),
    .may_eat    (may_eat),
    .fork_busy  (fork_busy),
    .eating     (eating),
    .waiting    (waiting),
    .proto_err  (proto_err)
  );

  int checks   = 0;
  int failures = 0;
  int iter     = 0;

  // Philo side
  bit           fifo_q [N][$];
  logic [N-1:0] hbits  = '0;
  logic [N-1:0] ph_eat = '0;
  int           owner  [N];
  int           grants [N];

  // Reference model
  logic [N-1:0] m_fork, m_eat, m_wait;
  bit           m_err;
  int           m_ptr;
  int           next_dec;
  logic [N-1:0] exp_ack [8];
  logic [N-1:0] exp_me  [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (iter %0d)", tag, got, exp, iter);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (fifo_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      fout_empty[i] = (fifo_q[i].size() == 0);
      fout_data[i]  = (fifo_q[i].size() == 0) ? 1'b0 : fifo_q[i][0];
    end
    hungry = hbits;
  endtask

  task automatic model_reset();
    m_fork = '0; m_eat = '0; m_wait = '0; m_err = 1'b0; m_ptr = 0;
    for (int s = 0; s < 8; s++) begin exp_ack[s] = '0; exp_me[s] = '0; end
    for (int i = 0; i < N; i++) owner[i] = -1;
    ph_eat = '0;
  endtask

  task automatic model_grant(input int p, input int at);
    m_fork[p] = 1'b1;
    m_fork[(p + 1) % N] = 1'b1;
    m_eat[p]  = 1'b1;
    m_wait[p] = 1'b0;
    exp_me[at % 8][p] = 1'b1;
  endtask

  // Service one event if the table is back in SCAN during this cycle.
  task automatic decide();
    int  found;
    int  l, r;
    bit  ev;
    if (reset || iter < next_dec) return;
    found = -1;
    for (int k = 0; k < N; k++) begin
      if (found < 0 && fifo_q[(m_ptr + k) % N].size() != 0) found = (m_ptr + k) % N;
    end
    if (found < 0) return;
    ev = fifo_q[found][0];
    l  = (found + N - 1) % N;
    r  = (found + 1) % N;
    exp_ack[(iter + 1) % 8][found] = 1'b1;
    if (ev == PHILO_HUNGRY) begin
      if (m_eat[found] || m_wait[found]) m_err = 1'b1;
      else if (!m_fork[found] && !m_fork[r]) model_grant(found, iter + 2);
      else m_wait[found] = 1'b1;
      next_dec = iter + 3;
    end else if (!m_eat[found]) begin
      m_err    = 1'b1;
      next_dec = iter + 3;
    end else begin
      m_fork[found] = 1'b0;
      m_fork[r]     = 1'b0;
      m_eat[found]  = 1'b0;
      if (m_wait[l] && !m_fork[l] && !m_fork[found]) model_grant(l, iter + 3);
      if (m_wait[r] && !m_fork[r] && !m_fork[(r + 1) % N]) model_grant(r, iter + 4);
      next_dec = iter + 5;
    end
    m_ptr = r;
  endtask

  // One clock: model decision, drive inputs, then observe at the falling edge.
  task automatic tick();
    decide();
    drive();
    @(negedge clk);
    iter++;
    if (!reset) begin
      check("fout_ack", 32'(fout_ack), 32'(exp_ack[iter % 8]));
      check("may_eat", 32'(may_eat), 32'(exp_me[iter % 8]));
      check("eat_wait_overlap", 32'(eating & waiting), 32'd0);
      if (iter >= next_dec) begin
        check("fork_busy", 32'(fork_busy), 32'(m_fork));
        check("eating", 32'(eating), 32'(m_eat));
        check("waiting", 32'(waiting), 32'(m_wait));
        check("proto_err", 32'(proto_err), 32'(m_err));
      end
      for (int i = 0; i < N; i++) begin
        if (may_eat[i]) begin
          int r;
          r = (i + 1) % N;
          check("fork_double_book", 32'(owner[i] < 0 && owner[r] < 0), 32'd1);
          owner[i] = i;
          owner[r] = i;
          ph_eat[i] = 1'b1;
          hbits[i]  = 1'b0;
          grants[i]++;
        end
        if (fout_ack[i] && fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
      end
    end
    exp_ack[iter % 8] = '0;
    exp_me[iter % 8]  = '0;
  endtask

  task automatic do_reset(input bit keep_fifos);
    reset = 1'b1;
    #1;
    check("reset_outputs", 32'({fout_ack, may_eat, fork_busy, eating, waiting, proto_err}), 32'd0);
    if (!keep_fifos) begin
      for (int i = 0; i < N; i++) fifo_q[i].delete();
      hbits = '0;
    end
    model_reset();
    drive();
    repeat (2) begin
      @(negedge clk);
      iter++;
    end
    reset    = 1'b0;
    next_dec = iter;
  endtask

  task automatic philo_hungry(input int i);
    fifo_q[i].push_back(PHILO_HUNGRY);
    hbits[i] = 1'b1;
  endtask

  task automatic philo_done(input int i);
    fifo_q[i].push_back(PHILO_DONE);
    ph_eat[i] = 1'b0;
    if (owner[i] == i) owner[i] = -1;
    if (owner[(i + 1) % N] == i) owner[(i + 1) % N] = -1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(iter >= next_dec && all_empty()) && n < budget) begin
      tick();
      n++;
    end
    check({"idle_", tag}, 32'(iter >= next_dec && all_empty()), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit drained;
    for (int i = 0; i < N; i++) grants[i] = 0;
    model_reset();
    drive();
    #2;
    do_reset(1'b0);

    // 1: single HUNGRY from philo 0
    philo_hungry(0);
    wait_idle("t1", 20);
    check("t1_fork_busy", 32'(fork_busy), 32'b00011);
    check("t1_eating", 32'(eating), 32'b00001);

    // 2: neighbour blocked, then released through CHK_R
    philo_hungry(1);
    wait_idle("t2a", 20);
    check("t2_waiting", 32'(waiting), 32'b00010);
    philo_done(0);
    wait_idle("t2b", 20);
    check("t2_fork_busy", 32'(fork_busy), 32'b00110);
    check("t2_eating", 32'(eating), 32'b00010);

    // 3: rr_ptr=2 after philo 1 finishes; 3 and 1 queued together
    philo_done(1);
    wait_idle("t3a", 20);
    philo_hungry(1);
    philo_hungry(3);
    wait_idle("t3b", 30);
    check("t3_eating", 32'(eating), 32'b01010);
    check("t3_fork_busy", 32'(fork_busy), 32'b11110);

    // 5a: repeated HUNGRY from philo 4
    philo_hungry(4);
    fifo_q[4].push_back(PHILO_HUNGRY);
    wait_idle("t5a", 30);
    check("t5_dup_hungry_err", 32'(proto_err), 32'd1);
    check("t5_waiting", 32'(waiting), 32'b10000);
    do_reset(1'b0);

    // 5b: DONE from a philo that is not eating
    philo_hungry(0);
    wait_idle("t5b", 20);
    fifo_q[2].push_back(PHILO_DONE);
    wait_idle("t5c", 20);
    check("t5_bad_done_err", 32'(proto_err), 32'd1);
    check("t5_fork_kept", 32'(fork_busy), 32'b00011);
    check("t5_popped", 32'(fifo_q[2].size()), 32'd0);
    do_reset(1'b0);

    // 6: reset while the table is in CHK_L; queued events serviced from rr_ptr=0
    philo_hungry(0);
    wait_idle("t6a", 20);
    philo_done(0);
    tick();
    philo_hungry(0);
    philo_hungry(2);
    tick();
    do_reset(1'b1);
    wait_idle("t6b", 30);
    check("t6_eating", 32'(eating), 32'b00101);
    check("t6_fork_busy", 32'(fork_busy), 32'b01111);

    // 4: everyone hungry at once, then random traffic
    philo_done(0);
    philo_done(2);
    wait_idle("t4a", 30);
    for (int i = 0; i < N; i++) grants[i] = 0;
    for (int i = 0; i < N; i++) philo_hungry(i);
    wait_idle("t4b", 60);
    check("t4_two_eating", 32'($countones(eating)), 32'd2);
    check("t4_non_adjacent", 32'(eating & {eating[0], eating[N-1:1]}), 32'd0);

    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!hbits[i] && !ph_eat[i] && !eating[i] && $urandom_range(0, 5) == 0) philo_hungry(i);
        else if (ph_eat[i] && $urandom_range(0, 7) == 0) philo_done(i);
      end
      tick();
    end

    drained = 1'b0;
    for (int n = 0; n < 800 && !drained; n++) begin
      for (int i = 0; i < N; i++) if (ph_eat[i]) philo_done(i);
      tick();
      drained = (hbits == '0) && (ph_eat == '0) && all_empty() && (iter >= next_dec);
    end
    check("t4_drained", 32'(drained), 32'd1);
    check("t4_proto_err", 32'(proto_err), 32'd0);
    check("t4_forks_free", 32'(fork_busy), 32'd0);
    for (int i = 0; i < N; i++) check($sformatf("t4_granted_%0d", i), 32'(grants[i] > 0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
